// File: rtl/rr_sched_pkg.sv
// Shared definitions for the round-robin scheduling kernel: default sizing
// and the pivot arithmetic used by the kernel's pivot registers.
package rr_sched_pkg;

  localparam int DEF_NCONSUMERS = 8;
  localparam int DEF_NBANKS     = 4;
  localparam int DEF_NPORTS     = 2;

  // Staggered starting pivot of kernel (bank, port), so that the ports of
  // one bank begin their rotation at different consumers.
  function automatic int unsigned pivot_init(input int unsigned bank,
                                             input int unsigned port,
                                             input int unsigned nbanks,
                                             input int unsigned nconsumers);
    return (port * nbanks + bank) % nconsumers;
  endfunction

  // Advance a pivot by one consumer. The wrap is an explicit compare so
  // that non-power-of-two consumer counts rotate correctly.
  function automatic int unsigned rr_next(input int unsigned pivot,
                                          input int unsigned nconsumers);
    return (pivot == nconsumers - 1) ? 0 : pivot + 1;
  endfunction

endpackage

// File: rtl/rr_scheduling_kernel_rr_pick.sv
// Rotating-priority first-set finder: returns the first set bit of mask
// when scanning upward from pivot and wrapping around to bit 0.
module rr_pick #(
  parameter int N  = 8,
  parameter int CW = 3
) (
  input  logic [N-1:0]  mask,
  input  logic [CW-1:0] pivot,
  output logic          valid,
  output logic [CW-1:0] idx
);

  // Two-pass scan: indices at or above the pivot first, then the wrapped part.
  always_comb begin
    // NOTE: combinational logic uses blocking '=' and assigns every output
    // a default first, so no path leaves a value held (no latch).
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!valid && mask[i] && (i >= int'(pivot))) begin
        valid = 1'b1;
        idx   = CW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!valid && mask[i] && (i < int'(pivot))) begin
        valid = 1'b1;
        idx   = CW'(i);
      end
    end
  end

endmodule

// File: rtl/rr_scheduling_kernel.sv
// Round-robin crossbar arbiter between NCONSUMERS requesters and
// NBANKS x NPORTS bank ports. Each (bank, port) kernel owns a free-running
// pivot; grants are combinational on the current pivots and requests.
module rr_scheduling_kernel
  import rr_sched_pkg::*;
#(
  parameter int NCONSUMERS = DEF_NCONSUMERS,
  parameter int NBANKS     = DEF_NBANKS,
  parameter int NPORTS     = DEF_NPORTS,
  localparam int NKERNELS  = NBANKS * NPORTS,
  localparam int CW        = $clog2(NCONSUMERS),
  localparam int BW        = (NBANKS > 1) ? $clog2(NBANKS) : 1,
  localparam int PW        = (NPORTS > 1) ? $clog2(NPORTS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NCONSUMERS-1:0]    req_valid,
  input  logic [NCONSUMERS*BW-1:0] req_bank,
  output logic [NCONSUMERS-1:0]    grant,
  output logic [NCONSUMERS*PW-1:0] grant_port,
  output logic [NKERNELS-1:0]      kernel_valid,
  output logic [NKERNELS*CW-1:0]   kernel_consumer
);

  typedef logic [CW-1:0] cid_t;
  typedef logic [BW-1:0] bid_t;
  typedef logic [PW-1:0] pid_t;

  cid_t rr_pivots   [NKERNELS];
  cid_t rr_pivots_d [NKERNELS];
  cid_t win_idx     [NKERNELS];

  // Every pivot advances by one each cycle, regardless of traffic.
  always_comb begin
    for (int k = 0; k < NKERNELS; k++) begin
      rr_pivots_d[k] = cid_t'(rr_next(32'(rr_pivots[k]), NCONSUMERS));
    end
  end

  // Pivot register array; reset reloads the staggered start values at once.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state is updated with non-blocking '<=' so every pivot samples
    // the pre-edge values; blocking here would create order-dependent races.
    if (reset) begin
      for (int k = 0; k < NKERNELS; k++) begin
        rr_pivots[k] <= cid_t'(pivot_init(k / NPORTS, k % NPORTS, NBANKS, NCONSUMERS));
      end
    end else begin
      for (int k = 0; k < NKERNELS; k++) begin
        rr_pivots[k] <= rr_pivots_d[k];
      end
    end
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    logic [NCONSUMERS-1:0] req_mask;
    // taken[p] holds consumers already won by ports below p of this bank.
    logic [NCONSUMERS-1:0] taken [NPORTS+1];

    // Consumers targeting this bank; out-of-range bank ids never match.
    always_comb begin
      req_mask = '0;
      for (int i = 0; i < NCONSUMERS; i++) begin
        req_mask[i] = req_valid[i] && (req_bank[i*BW +: BW] == bid_t'(b));
      end
    end

    assign taken[0] = '0;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
      localparam int K = b * NPORTS + p;
      logic [NCONSUMERS-1:0] cand;
      logic                  pick_valid;
      cid_t                  pick_idx;

      assign cand = req_mask & ~taken[p];

      rr_pick #(
        .N  (NCONSUMERS),
        .CW (CW)
      ) u_pick (
        .mask  (cand),
        .pivot (rr_pivots[K]),
        .valid (pick_valid),
        .idx   (pick_idx)
      );

      assign taken[p+1] = taken[p] |
                          (pick_valid ? (NCONSUMERS'(1) << pick_idx) : '0);

      assign kernel_valid[K]             = pick_valid;
      assign kernel_consumer[K*CW +: CW] = pick_idx;
      assign win_idx[K]                  = pick_idx;
    end
  end

  // Map each winning kernel back onto its consumer's grant and port.
  always_comb begin
    grant      = '0;
    grant_port = '0;
    for (int i = 0; i < NCONSUMERS; i++) begin
      for (int k = 0; k < NKERNELS; k++) begin
        if (kernel_valid[k] && (win_idx[k] == cid_t'(i))) begin
          grant[i]              = 1'b1;
          grant_port[i*PW +: PW] = pid_t'(k % NPORTS);
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_scheduling_kernel.sv
// Directed bench for rr_scheduling_kernel: default 8x4x2 instance plus a
// 6-consumer, 3-bank instance for non-power-of-two wrap and bad bank ids.
module tb_rr_scheduling_kernel;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  req_valid;
  logic [15:0] req_bank;
  logic [7:0]  grant;
  logic [7:0]  grant_port;
  logic [7:0]  kernel_valid;
  logic [23:0] kernel_consumer;

  logic [5:0]  req2_valid;
  logic [11:0] req2_bank;
  logic [5:0]  grant2;
  logic [5:0]  grant_port2;
  logic [5:0]  kernel_valid2;
  logic [17:0] kernel_consumer2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rr_scheduling_kernel dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_bank        (req_bank),
    .grant           (grant),
    .grant_port      (grant_port),
    .kernel_valid    (kernel_valid),
    .kernel_consumer (kernel_consumer)
  );

  rr_scheduling_kernel #(
    .NCONSUMERS (6),
    .NBANKS     (3),
    .NPORTS     (2)
  ) dut2 (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req2_valid),
    .req_bank        (req2_bank),
    .grant           (grant2),
    .grant_port      (grant_port2),
    .kernel_valid    (kernel_valid2),
    .kernel_consumer (kernel_consumer2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Pivots of the default instance, one nibble each, kernel 0 leftmost.
  function automatic logic [31:0] pivots();
    logic [31:0] v = '0;
    for (int k = 0; k < 8; k++) v = {v[27:0], 1'b0, dut.rr_pivots[k]};
    return v;
  endfunction

  function automatic logic [31:0] kcons(input int k);
    return 32'(kernel_consumer[k*3 +: 3]);
  endfunction

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_bank   = '0;
    req2_valid = 6'h3F;
    req2_bank  = 12'hFFF;   // every consumer asks for bank 3, which does not exist
    repeat (3) @(negedge clk);

    check("reset_pivots", pivots(), 32'h04152637);
    check("reset_idle_grant", 32'(grant), 32'h0);
    check("dut2_reset_pivot5", 32'(dut2.rr_pivots[5]), 32'd5);
    check("dut2_oob_grant", 32'(grant2), 32'h0);
    check("dut2_oob_kvalid", 32'(kernel_valid2), 32'h0);

    // Consumers 0,3,5 ask for bank 1; bank 1 pivots are {1,5}.
    req_valid = 8'b0010_1001;
    req_bank[0*2 +: 2] = 2'd1;
    req_bank[3*2 +: 2] = 2'd1;
    req_bank[5*2 +: 2] = 2'd1;
    #1;
    check("arb0_kvalid", 32'(kernel_valid), 32'h0C);
    check("arb0_port0", kcons(2), 32'd3);
    check("arb0_port1", kcons(3), 32'd5);
    check("arb0_grant", 32'(grant), 32'h28);
    check("arb0_gport", 32'(grant_port), 32'h20);

    reset = 1'b0;
    @(negedge clk);
    check("inc1_pivots", pivots(), 32'h15263740);
    check("dut2_wrap_pivot5", 32'(dut2.rr_pivots[5]), 32'd0);
    // Bank 1 pivots {2,6}: port0 scans 2,3 -> 3; port1 scans 6,7,0 -> 0.
    check("arb1_port0", kcons(2), 32'd3);
    check("arb1_port1", kcons(3), 32'd0);
    check("arb1_grant", 32'(grant), 32'h09);
    check("arb1_gport", 32'(grant_port), 32'h01);

    @(negedge clk);
    check("inc2_pivots", pivots(), 32'h26374051);

    repeat (6) @(negedge clk);
    check("wrap_pivots", pivots(), 32'h04152637);

    // Lone requester on bank 3; dut2 consumer 4 asks for bank 0.
    req_valid = 8'b0100_0000;
    req_bank[6*2 +: 2] = 2'd3;
    req2_bank[4*2 +: 2] = 2'd0;
    #1;
    check("single_kvalid", 32'(kernel_valid), 32'h40);
    check("single_k6", kcons(6), 32'd6);
    check("single_k7", kcons(7), 32'd0);
    check("single_grant", 32'(grant), 32'h40);
    check("single_gport", 32'(grant_port), 32'h00);
    check("dut2_b0_kvalid", 32'(kernel_valid2), 32'h01);
    check("dut2_b0_grant", 32'(grant2), 32'h10);
    check("dut2_b0_winner", 32'(kernel_consumer2[2:0]), 32'd4);

    req_valid = '0;
    #1;
    check("noreq_grant", 32'(grant), 32'h0);
    check("noreq_kvalid", 32'(kernel_valid), 32'h0);
    check("noreq_kcons", 32'(kernel_consumer), 32'h0);
    @(negedge clk);
    check("noreq_advance", pivots(), 32'h15263740);

    // Reset between edges must reload without waiting for the clock.
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reload", pivots(), 32'h04152637);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_reload_inc", pivots(), 32'h15263740);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
